outport_sched: RTL

- Per-output-port switch scheduler for the 5-port router.
- Each cycle it picks one of five input controllers whose head flit targets this output, using round-robin.
- It locks the output to the winning input from head flit through tail flit (wormhole).
- It tracks downstream buffer credits and drives the registered crossbar select and send strobe.

---
 rtl/outport_sched_pkg.sv | 23 ++
 rtl/outport_sched_rr_pick.sv | 32 +++
 rtl/outport_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/outport_sched_pkg.sv
// Shared constants, FSM encoding and helpers for the per-output scheduler.
package outport_sched_pkg;

  localparam int PORTW = 2;
  localparam int PORT = 4;
  localparam int PORT_P1 = 5;
  localparam int NPORT = PORT_P1;
  localparam int DSTW = 3;
  localparam int IDXW = 3;
  localparam int DEF_CREDITS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [IDXW-1:0] next_port(
    input logic [IDXW-1:0] i
  );
    return (i == IDXW'(PORT)) ? '0 : i + IDXW'(1);
  endfunction

endpackage

// File: rtl/outport_sched_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr,
// found by scanning a doubled request vector.
import outport_sched_pkg::*;

module rr_pick (
  input  logic [NPORT-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [NPORT-1:0] gnt,
  output logic [IDXW-1:0]  idx
);

  logic [2*NPORT-1:0] dbl;
  logic [3:0] pos;
  logic found;

  always_comb begin
    dbl = {req, req};
    idx = '0;
    pos = '0;
    found = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (!found && dbl[pos]) begin
        found = 1'b1;
        idx = (pos >= 4'(NPORT)) ?
          IDXW'(pos - 4'(NPORT)) : pos[IDXW-1:0];
      end
    end
    gnt = found ? (NPORT'(1) << idx) : '0;
  end

endmodule

// File: rtl/outport_sched.sv
// Per-output wormhole switch scheduler: round-robin head arbitration,
// packet lock until tail, downstream credit tracking.
import outport_sched_pkg::*;

module outport_sched #(
  parameter int PORTID = 0,
  parameter int NPORT = outport_sched_pkg::NPORT,
  parameter int CREDITS = DEF_CREDITS,
  parameter int CNTW = 3
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NPORT-1:0]      req,
  input  logic [DSTW*NPORT-1:0] dst,
  input  logic [NPORT-1:0]      head,
  input  logic [NPORT-1:0]      tail,
  input  logic                  credit_in,
  output logic [NPORT-1:0]      grt,
  output logic [NPORT-1:0]      sel,
  output logic                  send,
  output logic [CNTW-1:0]       credits,
  output logic                  busy,
  output logic                  cred_err
);

  localparam logic [DSTW-1:0] PID = DSTW'(PORTID);
  localparam logic [CNTW-1:0] FULL = CNTW'(CREDITS);

  state_t state, nstate;
  logic [IDXW-1:0] ptr, owner, pick_idx;
  logic [NPORT-1:0] elig, cand, pick_gnt, owner_oh;
  logic xfer, has_cred, win_tail, own_tail, own_req;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NPORT; i++)
      elig[i] = req[i] && (dst[DSTW*i +: DSTW] == PID);
  end

  // Only head flits may open a packet.
  assign cand = elig & head;

  rr_pick u_pick (
    .req(cand),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

  assign owner_oh = NPORT'(1) << owner;
  assign has_cred = (credits != '0);
  assign win_tail = tail[pick_idx];
  assign own_tail = tail[owner];
  assign own_req = elig[owner];
  assign xfer = |grt;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) state <= IDLE;
    else state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (xfer && !win_tail) nstate = LOCKED;
      LOCKED:
        if (xfer && own_tail) nstate = IDLE;
    endcase
  end

  always_comb begin
    grt = '0;
    if (!rst_ && has_cred) begin
      unique case (state)
        IDLE: grt = pick_gnt;
        LOCKED:
          if (own_req) grt = owner_oh;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      ptr <= '0;
      owner <= '0;
    end else if (xfer) begin
      unique case (state)
        IDLE:
          if (win_tail) ptr <= next_port(pick_idx);
          else owner <= pick_idx;
        LOCKED:
          if (own_tail) ptr <= next_port(owner);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      credits <= FULL;
      cred_err <= 1'b0;
    end else begin
      unique case ({xfer, credit_in})
        2'b10: credits <= credits - CNTW'(1);
        2'b01:
          if (credits != FULL) credits <= credits + CNTW'(1);
          else cred_err <= 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Registered strobes line up with the flit datapath stage.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      sel <= '0;
      send <= 1'b0;
      busy <= 1'b0;
    end else begin
      sel <= grt;
      send <= xfer;
      busy <= (nstate == LOCKED);
    end
  end

endmodule
